pc_fetch_unit: RTL and testbench

Program-counter and fetch sequencer for the multi-cycle datapath. It sits directly upstream of the per-opcode control decoders (CBZ/CBNZ, B.cond, ALU, load/store, ...). It fetches the instruction at PC, holds it in the instruction register, and drives the decoders' `instruction`, `state` and `status` inputs. It consumes the decoder's `Psel`, `PCsel`, `SL`, `K` and `nextState` to advance PC, the microstate and the status flags.

---
 rtl/pc_fetch_unit.sv | 118 +++++++++++
 tb/tb_pc_fetch_unit.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// pc_fetch_unit
// Program-counter and fetch sequencer for the multi-cycle datapath. Fetches
// the instruction at PC into the instruction register, presents IR, the
// current microstate and the latched flags to the per-opcode decoders, and
// consumes the decoder control word (Psel, PCsel, SL, K, nextState) to advance
// PC, the microstate and the flags.
//
// Ports
//   clock, reset       : single clock, asynchronous active-low reset
//   imem_req/imem_addr : fetch request and address (address is always PC)
//   imem_ack/imem_data : memory response, honoured only while fetching
//   instruction        : instruction register to decoders
//   state, status      : microstate and {V,C,Z,N} flags to decoders
//   exec_valid         : high while executing; decoder inputs used only then
//   PC, PC4            : program counter and PC+4 (BL link value)
//   Psel, PCsel, SL, K, regA, nextState, status_in : decoder / ALU inputs
// ---------------------------------------------------------------------------
module pc_fetch_unit #(
   parameter int unsigned      WIDTH    = 64,
   parameter logic [WIDTH-1:0] RESET_PC = '0
) (
   input  logic             clock,
   input  logic             reset,
   output logic             imem_req,
   output logic [WIDTH-1:0] imem_addr,
   input  logic             imem_ack,
   input  logic [31:0]      imem_data,
   output logic [31:0]      instruction,
   output logic [1:0]       state,
   output logic [3:0]       status,
   output logic             exec_valid,
   output logic [WIDTH-1:0] PC,
   output logic [WIDTH-1:0] PC4,
   input  logic [1:0]       Psel,
   input  logic             PCsel,
   input  logic             SL,
   input  logic [WIDTH-1:0] K,
   input  logic [WIDTH-1:0] regA,
   input  logic [1:0]       nextState,
   input  logic [3:0]       status_in
);

   localparam logic [0:0]       S_FETCH = 1'b0;
   localparam logic [0:0]       S_EXEC  = 1'b1;
   localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(4);

   logic [0:0]       fsm_p0;
   logic [WIDTH-1:0] pc_p0;
   logic [31:0]      ir_p0;
   logic [1:0]       state_p0;
   logic [3:0]       status_p0;

   logic [WIDTH-1:0] pc_plus4;
   logic [WIDTH-1:0] operand;
   logic [WIDTH-1:0] pc_next;

   // PC update selection; all sums wrap modulo 2^WIDTH and the shift drops
   // the top two operand bits.
   function automatic logic [WIDTH-1:0] next_pc(input logic [1:0]       sel,
                                                input logic [WIDTH-1:0] pc,
                                                input logic [WIDTH-1:0] pc4,
                                                input logic [WIDTH-1:0] opnd);
      logic [WIDTH-1:0] res;
      case (sel)
         2'b01:   res = pc4;
         2'b10:   res = opnd;
         2'b11:   res = pc4 + (opnd << 2);
         default: res = pc;
      endcase
      return res;
   endfunction

   assign pc_plus4 = pc_p0 + PC_STEP;
   assign operand  = PCsel ? K : regA;
   assign pc_next  = next_pc(Psel, pc_p0, pc_plus4, operand);

   // Request depends only on registered state and reset, never on decoder
   // inputs; reset gates it so no request is visible while reset is held.
   assign imem_req    = (fsm_p0 == S_FETCH) && reset;
   assign imem_addr   = pc_p0;
   assign exec_valid  = (fsm_p0 == S_EXEC);
   assign instruction = ir_p0;
   assign state       = state_p0;
   assign status      = status_p0;
   assign PC          = pc_p0;
   assign PC4         = pc_plus4;

   // ---- stage p0: fetch / execute sequencing ----
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         fsm_p0    <= S_FETCH;
         pc_p0     <= RESET_PC;
         ir_p0     <= '0;
         state_p0  <= 2'b00;
         status_p0 <= 4'b0000;
      end else if (fsm_p0 == S_FETCH) begin
         if (imem_ack) begin
            ir_p0    <= imem_data;
            state_p0 <= 2'b00;
            fsm_p0   <= S_EXEC;
         end
      end else begin
         pc_p0 <= pc_next;
         if (SL) begin
            status_p0 <= status_in;
         end
         // nextState of 00 marks the last microstate of the instruction.
         if (nextState == 2'b00) begin
            state_p0 <= 2'b00;
            fsm_p0   <= S_FETCH;
         end else begin
            state_p0 <= nextState;
         end
      end
   end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch_unit
// Self-checking bench for pc_fetch_unit (WIDTH=64, RESET_PC=0). A behavioural
// model of the fetch/execute rules tracks PC, IR, microstate, flags and phase.
// ---------------------------------------------------------------------------
module tb_pc_fetch_unit;

   logic        clock;
   logic        reset;
   logic        imem_req;
   logic [63:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_data;
   logic [31:0] instruction;
   logic [1:0]  state;
   logic [3:0]  status;
   logic        exec_valid;
   logic [63:0] PC;
   logic [63:0] PC4;
   logic [1:0]  Psel;
   logic        PCsel;
   logic        SL;
   logic [63:0] K;
   logic [63:0] regA;
   logic [1:0]  nextState;
   logic [3:0]  status_in;

   int errors = 0;
   int checks = 0;

   // behavioural model
   logic [63:0] m_pc;
   logic [31:0] m_ir;
   logic [1:0]  m_state;
   logic [3:0]  m_status;
   bit          m_exec;

   // values sampled just before the active edge, and their expectations
   logic        s_req;
   logic [63:0] s_addr;
   logic        e_req;
   logic [63:0] e_addr;

   pc_fetch_unit #(.WIDTH(64), .RESET_PC(64'd0)) dut (
      .clock(clock), .reset(reset),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_data(imem_data),
      .instruction(instruction), .state(state), .status(status),
      .exec_valid(exec_valid), .PC(PC), .PC4(PC4),
      .Psel(Psel), .PCsel(PCsel), .SL(SL), .K(K), .regA(regA),
      .nextState(nextState), .status_in(status_in)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic model_reset();
      m_pc = 64'd0; m_ir = 32'd0; m_state = 2'b00; m_status = 4'b0000; m_exec = 0;
   endtask

   // One clock cycle: drive at the falling edge, capture the request just
   // before the rising edge, advance the model on the rising edge.
   task automatic step(input bit ack, input logic [31:0] d, input logic [1:0] ps,
                       input bit pcs, input bit sl, input logic [63:0] k,
                       input logic [63:0] ra, input logic [1:0] ns, input logic [3:0] si);
      logic [63:0] opnd;
      @(negedge clock);
      imem_ack = ack; imem_data = d; Psel = ps; PCsel = pcs; SL = sl;
      K = k; regA = ra; nextState = ns; status_in = si;
      #1;
      s_req = imem_req; s_addr = imem_addr; e_req = !m_exec; e_addr = m_pc;
      @(posedge clock);
      if (!m_exec) begin
         if (ack) begin m_ir = d; m_state = 2'b00; m_exec = 1; end
      end else begin
         opnd = pcs ? k : ra;
         case (ps)
            2'd1: m_pc = m_pc + 64'd4;
            2'd2: m_pc = opnd;
            2'd3: m_pc = m_pc + 64'd4 + opnd * 64'd4;
            default: ;
         endcase
         if (sl) m_status = si;
         if (ns == 2'b00) begin m_exec = 0; m_state = 2'b00; end
         else m_state = ns;
      end
      #1;
   endtask

   task automatic fetch(input logic [31:0] d);
      step(1'b1, d, 2'b00, 1'b0, 1'b0, 64'd0, 64'd0, 2'b00, 4'b0000);
   endtask

   task automatic exe(input logic [1:0] ps, input bit pcs, input bit sl, input logic [63:0] k,
                      input logic [63:0] ra, input logic [1:0] ns, input logic [3:0] si);
      step(1'b0, 32'd0, ps, pcs, sl, k, ra, ns, si);
   endtask

   // Execute a one-cycle absolute branch through K to land on addr in FETCH.
   task automatic goto_pc(input logic [63:0] addr);
      fetch($urandom);
      exe(2'b10, 1'b1, 1'b0, addr, 64'd0, 2'b00, 4'b0000);
   endtask

   task automatic test_reset();
      reset = 1'b0; imem_ack = 0; imem_data = 0; Psel = 0; PCsel = 0; SL = 0;
      K = 0; regA = 0; nextState = 0; status_in = 0;
      model_reset();
      @(posedge clock); #1;
      checks++; if (PC !== 64'd0) begin errors++; $display("FAIL rst_pc: got %h want 0", PC); end
      checks++; if (PC4 !== 64'd4) begin errors++; $display("FAIL rst_pc4: got %h want 4", PC4); end
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", imem_req); end
      checks++; if ({exec_valid, instruction, state, status} !== 39'd0)
         begin errors++; $display("FAIL rst_regs: ev=%b ir=%h st=%b fl=%b want all 0", exec_valid, instruction, state, status); end
      @(negedge clock); reset = 1'b1; #1;
      checks++; if (imem_req !== 1'b1 || imem_addr !== 64'd0)
         begin errors++; $display("FAIL rst_first_req: req=%b addr=%h want 1/0", imem_req, imem_addr); end
   endtask

   task automatic test_reset_mid_fetch();
      goto_pc(64'h40);
      fetch($urandom);
      exe(2'b00, 1'b0, 1'b1, 64'd0, 64'd0, 2'b00, 4'b0110);
      step(1'b0, 32'd0, 2'b00, 1'b0, 1'b0, 64'd0, 64'd0, 2'b00, 4'b0000);
      checks++; if (s_req !== 1'b1 || s_addr !== 64'h40)
         begin errors++; $display("FAIL mid_pre_req: req=%b addr=%h want 1/40", s_req, s_addr); end
      @(negedge clock); #2;
      imem_ack = 1'b1; imem_data = 32'hDEADBEEF;
      reset = 1'b0; #1;
      model_reset();
      checks++; if (PC !== 64'd0 || imem_req !== 1'b0 || status !== 4'd0 || state !== 2'd0)
         begin errors++; $display("FAIL mid_async: pc=%h req=%b st=%b fl=%b want 0", PC, imem_req, state, status); end
      @(posedge clock);
      @(negedge clock); reset = 1'b1; imem_ack = 1'b0; #1;
      checks++; if (imem_req !== 1'b1 || imem_addr !== 64'd0 || exec_valid !== 1'b0 || instruction !== 32'd0)
         begin errors++; $display("FAIL mid_release: req=%b addr=%h ev=%b ir=%h want 1/0/0/0", imem_req, imem_addr, exec_valid, instruction); end
   endtask

   task automatic test_sequential();
      logic [31:0] d;
      for (int i = 0; i < 3; i++) begin
         d = $urandom;
         fetch(d);
         checks++; if (s_req !== 1'b1 || s_addr !== 64'(i * 4))
            begin errors++; $display("FAIL seq_addr%0d: req=%b addr=%h want 1/%h", i, s_req, s_addr, 64'(i * 4)); end
         checks++; if (exec_valid !== 1'b1 || instruction !== d)
            begin errors++; $display("FAIL seq_ir%0d: ev=%b ir=%h want 1/%h", i, exec_valid, instruction, d); end
         exe(2'b01, 1'b0, 1'b0, 64'd0, 64'd0, 2'b00, 4'b0000);
         checks++; if (s_req !== 1'b0 || exec_valid !== 1'b0 || PC !== 64'((i + 1) * 4))
            begin errors++; $display("FAIL seq_exec%0d: req=%b ev=%b pc=%h want 0/0/%h", i, s_req, exec_valid, PC, 64'((i + 1) * 4)); end
      end
   endtask

   task automatic test_cbz();
      goto_pc(64'h100);
      fetch($urandom);
      exe(2'b11, 1'b1, 1'b0, 64'd3, 64'($urandom), 2'b00, 4'b0000);
      checks++; if (PC !== 64'h110) begin errors++; $display("FAIL cbz_taken: got %h want 110", PC); end
      goto_pc(64'h100);
      fetch($urandom);
      exe(2'b01, 1'b1, 1'b0, 64'd3, 64'($urandom), 2'b00, 4'b0000);
      checks++; if (PC !== 64'h104) begin errors++; $display("FAIL cbz_not_taken: got %h want 104", PC); end
   endtask

   task automatic test_br();
      fetch($urandom);
      exe(2'b10, 1'b0, 1'b0, 64'($urandom), 64'h2000, 2'b00, 4'b0000);
      checks++; if (PC !== 64'h2000) begin errors++; $display("FAIL br_pc: got %h want 2000", PC); end
      fetch($urandom);
      checks++; if (s_req !== 1'b1 || s_addr !== 64'h2000)
         begin errors++; $display("FAIL br_fetch: req=%b addr=%h want 1/2000", s_req, s_addr); end
      exe(2'b01, 1'b0, 1'b0, 64'd0, 64'd0, 2'b00, 4'b0000);
   endtask

   task automatic test_multistate();
      logic [63:0] pc0;
      logic [3:0]  fl0;
      pc0 = m_pc; fl0 = m_status;
      fetch($urandom);
      checks++; if (state !== 2'b00) begin errors++; $display("FAIL ms_state0: got %b want 00", state); end
      exe(2'b00, 1'b0, 1'b0, 64'd0, 64'd0, 2'b01, 4'b1010);
      checks++; if (state !== 2'b01 || PC !== pc0 || status !== fl0 || exec_valid !== 1'b1)
         begin errors++; $display("FAIL ms_cycle1: st=%b pc=%h fl=%b ev=%b want 01/%h/%b/1", state, PC, status, exec_valid, pc0, fl0); end
      exe(2'b01, 1'b0, 1'b1, 64'd0, 64'd0, 2'b00, 4'b1010);
      checks++; if (state !== 2'b00 || PC !== pc0 + 64'd4 || status !== 4'b1010 || exec_valid !== 1'b0)
         begin errors++; $display("FAIL ms_cycle2: st=%b pc=%h fl=%b ev=%b want 00/%h/1010/0", state, PC, status, exec_valid, pc0 + 64'd4); end
   endtask

   task automatic test_wait_wrap();
      logic [63:0] pc0;
      logic [31:0] ir0;
      logic [31:0] d;
      int          reqs;
      pc0 = m_pc; ir0 = m_ir; d = $urandom; reqs = 0;
      for (int c = 0; c < 3; c++) begin
         step(1'b0, $urandom, 2'b11, 1'b1, 1'b1, 64'($urandom), 64'($urandom), 2'b01, 4'($urandom));
         if (s_req === 1'b1) reqs++;
         checks++; if (PC !== pc0 || instruction !== ir0 || exec_valid !== 1'b0)
            begin errors++; $display("FAIL wait_hold%0d: pc=%h ir=%h ev=%b want %h/%h/0", c, PC, instruction, exec_valid, pc0, ir0); end
      end
      fetch(d);
      if (s_req === 1'b1) reqs++;
      checks++; if (reqs != 4 || instruction !== d)
         begin errors++; $display("FAIL wait_req: req cycles=%0d ir=%h want 4/%h", reqs, instruction, d); end
      step(1'b1, ~d, 2'b00, 1'b0, 1'b0, 64'd0, 64'd0, 2'b01, 4'b0000);
      checks++; if (instruction !== d || state !== 2'b01)
         begin errors++; $display("FAIL stray_ack: ir=%h st=%b want %h/01", instruction, state, d); end
      exe(2'b00, 1'b0, 1'b0, 64'd0, 64'd0, 2'b00, 4'b0000);
      goto_pc(64'hFFFF_FFFF_FFFF_FFFC);
      checks++; if (PC4 !== 64'd0) begin errors++; $display("FAIL wrap_pc4: got %h want 0", PC4); end
      fetch($urandom);
      exe(2'b01, 1'b0, 1'b0, 64'd0, 64'd0, 2'b00, 4'b0000);
      checks++; if (PC !== 64'd0) begin errors++; $display("FAIL wrap_pc: got %h want 0", PC); end
   endtask

   task automatic test_random();
      logic [1:0] ns;
      for (int i = 0; i < 300; i++) begin
         ns = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
         step(1'($urandom), $urandom, 2'($urandom), 1'($urandom), 1'($urandom),
              {$urandom, $urandom}, {$urandom, $urandom}, ns, 4'($urandom));
         checks++; if (s_req !== e_req || s_addr !== e_addr)
            begin errors++; $display("FAIL rnd_req%0d: req=%b addr=%h want %b/%h", i, s_req, s_addr, e_req, e_addr); end
         checks++; if ({PC, PC4, instruction, state, status, exec_valid} !==
                       {m_pc, m_pc + 64'd4, m_ir, m_state, m_status, m_exec})
            begin errors++; $display("FAIL rnd_state%0d: pc=%h ir=%h st=%b fl=%b ev=%b want %h/%h/%b/%b/%b",
                                     i, PC, instruction, state, status, exec_valid, m_pc, m_ir, m_state, m_status, m_exec); end
      end
   endtask

   initial begin
      test_reset();
      test_reset_mid_fetch();
      test_sequential();
      test_cbz();
      test_br();
      test_multistate();
      test_wait_wrap();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
